// File: rtl/debug_frame_rx.sv
//============================================================================
// Module   : debug_frame_rx
// Purpose  : Hunts for the 2-byte host sync word in the UART byte stream,
//            collects one fixed-length debug command frame, checks it with
//            CRC-16/CCITT-FALSE and offers cmd/payload to the command
//            decoder over a valid/ready handshake.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            uart_rx_valid/data  - one-cycle byte strobe from the UART
//            frame_valid/ready   - frame handshake to the decoder
//            frame_cmd/payload   - command byte, payload (first byte in MSBs)
//            crc_error           - pulse: frame complete, CRC bad
//            timeout_error       - pulse: frame aborted, inter-byte timeout
//            overrun             - pulse: byte dropped while holding a frame
//            busy                - receiver is not idle-hunting
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module debug_frame_rx #(
  parameter int                      DATA_WIDTH     = 8,
  parameter logic [2*DATA_WIDTH-1:0] SYNC_WORD      = 16'h5AA5,
  parameter int                      PAYLOAD_BYTES  = 7,
  parameter int                      FRAME_LENGTH   = 12,  // PAYLOAD_BYTES + 5
  parameter int                      TIMEOUT_CYCLES = 50000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                uart_rx_valid,
  input  logic [DATA_WIDTH-1:0]               uart_rx_data,
  output logic                                frame_valid,
  input  logic                                frame_ready,
  output logic [DATA_WIDTH-1:0]               frame_cmd,
  output logic [PAYLOAD_BYTES*DATA_WIDTH-1:0] frame_payload,
  output logic                                crc_error,
  output logic                                timeout_error,
  output logic                                overrun,
  output logic                                busy
);

  localparam int CNT_W = $clog2(FRAME_LENGTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SHR_W = (PAYLOAD_BYTES + 1) * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] SYNC_HI = SYNC_WORD[2*DATA_WIDTH-1:DATA_WIDTH];
  localparam logic [DATA_WIDTH-1:0] SYNC_LO = SYNC_WORD[DATA_WIDTH-1:0];

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT_MAX = CNT_W'(FRAME_LENGTH - 3);
  localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX       = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  // One-hot state encoding
  localparam logic [4:0] S_HUNT0   = 5'b00001;
  localparam logic [4:0] S_HUNT1   = 5'b00010;
  localparam logic [4:0] S_COLLECT = 5'b00100;
  localparam logic [4:0] S_CHECK   = 5'b01000;
  localparam logic [4:0] S_HOLD    = 5'b10000;

  logic [4:0]       state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SHR_W-1:0] shr_q, shr_d;
  logic             frame_valid_q, frame_valid_d;
  logic             crc_error_q, crc_error_d;
  logic             timeout_error_q, timeout_error_d;
  logic             overrun_q, overrun_d;

  // Bit-serial MSB-first CRC step, unrolled across one data word.
  function automatic logic [15:0] crc_update(input logic [15:0] crc_in,
                                             input logic [DATA_WIDTH-1:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0]      w_crc_upd;
  logic [15:0]      w_crc_seed;
  logic             w_tmo_expire;
  logic [TMO_W-1:0] w_tmo_inc;

  assign w_crc_upd    = crc_update(crc_q, uart_rx_data);
  assign w_crc_seed   = crc_update(CRC_INIT, uart_rx_data);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_tmo_expire = !uart_rx_valid && (tmo_q >= TMO_LAST);
  assign w_tmo_inc    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_HUNT0;
      crc_q           <= CRC_INIT;
      cnt_q           <= '0;
      tmo_q           <= '0;
      shr_q           <= '0;
      frame_valid_q   <= 1'b0;
      crc_error_q     <= 1'b0;
      timeout_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      crc_q           <= crc_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      shr_q           <= shr_d;
      frame_valid_q   <= frame_valid_d;
      crc_error_q     <= crc_error_d;
      timeout_error_q <= timeout_error_d;
      overrun_q       <= overrun_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    shr_d   = shr_q;
    case (state_q)
      S_HUNT0: begin
        crc_d = CRC_INIT;
        cnt_d = '0;
        if (uart_rx_valid && (uart_rx_data == SYNC_HI)) begin
          crc_d   = w_crc_upd;
          state_d = S_HUNT1;
        end
      end
      S_HUNT1: begin
        if (uart_rx_valid) begin
          if (uart_rx_data == SYNC_LO) begin
            crc_d   = w_crc_upd;
            cnt_d   = CNT_W'(2);
            state_d = S_COLLECT;
          end else if (uart_rx_data == SYNC_HI) begin
            // Repeated high sync byte: restart the CRC as if this one opened the frame.
            crc_d = w_crc_seed;
          end else begin
            crc_d   = CRC_INIT;
            state_d = S_HUNT0;
          end
        end else if (w_tmo_expire) begin
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          state_d = S_HUNT0;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end
      S_COLLECT: begin
        if (uart_rx_valid) begin
          crc_d = w_crc_upd;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q <= CNT_SHIFT_MAX) begin
            shr_d = {shr_q[SHR_W-DATA_WIDTH-1:0], uart_rx_data};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_CHECK;
          end
        end else if (w_tmo_expire) begin
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          state_d = S_HUNT0;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end
      S_CHECK: begin
        // Both CRC bytes are folded in, so a clean frame leaves zero residue.
        crc_d   = CRC_INIT;
        cnt_d   = '0;
        state_d = (crc_q == 16'h0000) ? S_HOLD : S_HUNT0;
      end
      S_HOLD: begin
        if (frame_valid_q && frame_ready) begin
          state_d = S_HUNT0;
        end
      end
      default: begin
        crc_d   = CRC_INIT;
        cnt_d   = '0;
        state_d = S_HUNT0;
      end
    endcase
  end

  // Output logic (registered one cycle later)
  always_comb begin
    frame_valid_d   = 1'b0;
    crc_error_d     = 1'b0;
    timeout_error_d = 1'b0;
    overrun_d       = 1'b0;
    case (state_q)
      S_HUNT1, S_COLLECT: timeout_error_d = w_tmo_expire;
      S_CHECK: begin
        if (crc_q == 16'h0000) begin
          frame_valid_d = 1'b1;
        end else begin
          crc_error_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Bytes are never hunted while holding, even in the handshake cycle.
        overrun_d     = uart_rx_valid;
        frame_valid_d = frame_valid_q && !frame_ready;
      end
      default: begin
        frame_valid_d = 1'b0;
      end
    endcase
  end

  assign frame_valid   = frame_valid_q;
  assign crc_error     = crc_error_q;
  assign timeout_error = timeout_error_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != S_HUNT0);
  assign frame_cmd     = shr_q[SHR_W-1 -: DATA_WIDTH];
  assign frame_payload = shr_q[PAYLOAD_BYTES*DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_debug_frame_rx.sv
//============================================================================
// Module   : tb_debug_frame_rx
// Purpose  : Directed self-checking bench for debug_frame_rx.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_debug_frame_rx;

  localparam int TMO = 16;

  logic        clk;
  logic        reset;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  frame_cmd;
  logic [55:0] frame_payload;
  logic        crc_error;
  logic        timeout_error;
  logic        overrun;
  logic        busy;

  debug_frame_rx #(
    .DATA_WIDTH    (8),
    .SYNC_WORD     (16'h5AA5),
    .PAYLOAD_BYTES (7),
    .FRAME_LENGTH  (12),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_cmd    (frame_cmd),
    .frame_payload(frame_payload),
    .crc_error    (crc_error),
    .timeout_error(timeout_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  int          n_crc = 0, n_tmo = 0, n_ovr = 0, n_fv_rise = 0, n_fv_cyc = 0, n_pl_chg = 0;
  int          fv_rise_cyc = 0, tmo_cyc = 0;
  logic        fv_prev = 1'b0;
  logic [7:0]  cap_cmd = '0;
  logic [55:0] cap_pl = '0, pl_prev = '0;
  always @(negedge clk) begin
    if (crc_error)     n_crc++;
    if (overrun)       n_ovr++;
    if (timeout_error) begin n_tmo++; tmo_cyc = cyc; end
    if (frame_valid) n_fv_cyc++;
    if (frame_valid && !fv_prev) begin
      n_fv_rise++;
      fv_rise_cyc = cyc;
      cap_cmd     = frame_cmd;
      cap_pl      = frame_payload;
    end
    if (frame_valid && fv_prev && (frame_payload !== pl_prev)) n_pl_chg++;
    fv_prev = frame_valid;
    pl_prev = frame_payload;
  end

  int b_crc, b_tmo, b_ovr, b_fv, b_fvc, b_plc;
  task automatic snap();
    b_crc = n_crc; b_tmo = n_tmo; b_ovr = n_ovr;
    b_fv = n_fv_rise; b_fvc = n_fv_cyc; b_plc = n_pl_chg;
  endtask

  // Golden CRC-16/CCITT-FALSE, byte-at-a-time form
  function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  logic [7:0] fr [12];
  task automatic build_frame(input logic [7:0] cmd, input logic [55:0] pl, input logic [7:0] corrupt);
    logic [15:0] c;
    fr[0] = 8'h5A; fr[1] = 8'hA5; fr[2] = cmd;
    for (int i = 0; i < 7; i++) fr[3+i] = pl[55-8*i -: 8];
    c = 16'hFFFF;
    for (int i = 0; i < 10; i++) c = crc_model(c, fr[i]);
    fr[10] = c[15:8];
    fr[11] = c[7:0] ^ corrupt;
  endtask

  int strobe_cyc = 0;
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = b; strobe_cyc = cyc;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(fr[i]);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_fv(input int max_cyc, input string name);
    int i;
    for (i = 0; i < max_cyc && !frame_valid; i++) @(negedge clk);
    if (!frame_valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s: frame_valid not seen within %0d cycles", name, max_cyc);
    end
  endtask

  //--------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b exp 0", frame_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if ({crc_error, timeout_error, overrun} !== 3'b000) begin n_fail++;
      $display("FAIL rst_err: got %b exp 000", {crc_error, timeout_error, overrun}); end
    n_tests++; if ({frame_cmd, frame_payload} !== 64'h0) begin n_fail++;
      $display("FAIL rst_data: got %h exp 0", {frame_cmd, frame_payload}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    snap();
    build_frame(8'h01, 56'h11223344556677, 8'h00);
    send_range(0, 11);
    repeat (5) @(negedge clk);
    n_tests++; if (n_fv_rise - b_fv !== 1) begin n_fail++; $display("FAIL good_rise: got %0d exp 1", n_fv_rise - b_fv); end
    n_tests++; if (n_fv_cyc - b_fvc !== 1) begin n_fail++; $display("FAIL good_fv_len: got %0d exp 1", n_fv_cyc - b_fvc); end
    n_tests++; if (fv_rise_cyc - strobe_cyc !== 2) begin n_fail++;
      $display("FAIL good_latency: got %0d exp 2", fv_rise_cyc - strobe_cyc); end
    n_tests++; if (cap_cmd !== 8'h01) begin n_fail++; $display("FAIL good_cmd: got %h exp 01", cap_cmd); end
    n_tests++; if (cap_pl !== 56'h11223344556677) begin n_fail++;
      $display("FAIL good_payload: got %h exp 11223344556677", cap_pl); end
    n_tests++; if ((n_crc - b_crc) + (n_tmo - b_tmo) + (n_ovr - b_ovr) !== 0) begin n_fail++;
      $display("FAIL good_errs: got %0d pulses exp 0", (n_crc - b_crc) + (n_tmo - b_tmo) + (n_ovr - b_ovr)); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b exp 0", busy); end
  endtask

  task automatic test_crc_error();
    snap();
    build_frame(8'h01, 56'h11223344556677, 8'h01);
    send_range(0, 11);
    repeat (3) @(negedge clk);
    n_tests++; if (n_crc - b_crc !== 1) begin n_fail++; $display("FAIL crc_pulse: got %0d exp 1", n_crc - b_crc); end
    n_tests++; if (n_fv_rise - b_fv !== 0) begin n_fail++; $display("FAIL crc_fv: got %0d exp 0", n_fv_rise - b_fv); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL crc_busy: got %b exp 0", busy); end
    // Follow-up frame carries sync values inside the payload
    build_frame(8'hC3, 56'h5AA5DEADBEEF00, 8'h00);
    send_range(0, 11);
    repeat (5) @(negedge clk);
    n_tests++; if (n_fv_rise - b_fv !== 1) begin n_fail++; $display("FAIL crc_next_rise: got %0d exp 1", n_fv_rise - b_fv); end
    n_tests++; if ({cap_cmd, cap_pl} !== {8'hC3, 56'h5AA5DEADBEEF00}) begin n_fail++;
      $display("FAIL crc_next_data: got %h exp C35AA5DEADBEEF00", {cap_cmd, cap_pl}); end
    n_tests++; if (n_crc - b_crc !== 1) begin n_fail++; $display("FAIL crc_next_err: got %0d exp 1", n_crc - b_crc); end
  endtask

  task automatic test_resync();
    snap();
    build_frame(8'h01, 56'h11223344556677, 8'h00);
    send_byte(8'h00); send_byte(8'h5A);
    send_range(0, 11);
    repeat (5) @(negedge clk);
    n_tests++; if (n_fv_rise - b_fv !== 1) begin n_fail++; $display("FAIL resync_rise: got %0d exp 1", n_fv_rise - b_fv); end
    n_tests++; if (cap_pl !== 56'h11223344556677) begin n_fail++;
      $display("FAIL resync_payload: got %h exp 11223344556677", cap_pl); end
    snap();
    send_byte(8'h5A); send_byte(8'h00);
    send_range(1, 11);
    repeat (25) @(negedge clk);
    n_tests++; if (n_fv_rise - b_fv !== 0) begin n_fail++; $display("FAIL broken_sync_rise: got %0d exp 0", n_fv_rise - b_fv); end
    n_tests++; if (n_crc - b_crc !== 0) begin n_fail++; $display("FAIL broken_sync_crc: got %0d exp 0", n_crc - b_crc); end
  endtask

  task automatic test_hold_overrun();
    snap();
    frame_ready = 1'b0;
    build_frame(8'h7E, 56'h0102030405A55A, 8'h00);
    send_range(0, 11);
    wait_fv(10, "hold_wait");
    repeat (3) @(negedge clk); send_byte(8'h5A);
    repeat (3) @(negedge clk); send_byte(8'hA5);
    repeat (9) @(negedge clk);
    n_tests++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL hold_still_valid: got %b exp 1", frame_valid); end
    n_tests++; if (frame_payload !== 56'h0102030405A55A) begin n_fail++;
      $display("FAIL hold_payload: got %h exp 0102030405A55A", frame_payload); end
    // Handshake and a third byte in the same cycle
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h01; frame_ready = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b exp 0", frame_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got %b exp 0", busy); end
    repeat (25) @(negedge clk);
    n_tests++; if (n_ovr - b_ovr !== 3) begin n_fail++; $display("FAIL hold_overrun: got %0d exp 3", n_ovr - b_ovr); end
    n_tests++; if (n_pl_chg - b_plc !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d changes exp 0", n_pl_chg - b_plc); end
    n_tests++; if ((n_tmo - b_tmo) + (n_fv_rise - b_fv) !== 1) begin n_fail++;
      $display("FAIL hold_no_hunt: got %0d tmo+frames exp 1", (n_tmo - b_tmo) + (n_fv_rise - b_fv)); end
  endtask

  task automatic test_timeout();
    int s;
    snap();
    build_frame(8'h01, 56'h11223344556677, 8'h00);
    send_range(0, 2);
    s = strobe_cyc;
    repeat (TMO + 4) @(negedge clk);
    n_tests++; if (n_tmo - b_tmo !== 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d exp 1", n_tmo - b_tmo); end
    n_tests++; if (tmo_cyc - s !== TMO + 1) begin n_fail++; $display("FAIL tmo_cycle: got %0d exp %0d", tmo_cyc - s, TMO + 1); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b exp 0", busy); end
    // Byte lands on the expiry cycle: must win
    snap();
    send_range(0, 3);
    s = strobe_cyc;
    while (cyc < s + TMO - 1) @(negedge clk);
    send_range(4, 11);
    repeat (5) @(negedge clk);
    n_tests++; if (n_tmo - b_tmo !== 0) begin n_fail++; $display("FAIL tmo_edge_pulse: got %0d exp 0", n_tmo - b_tmo); end
    n_tests++; if (n_fv_rise - b_fv !== 1) begin n_fail++; $display("FAIL tmo_edge_rise: got %0d exp 1", n_fv_rise - b_fv); end
  endtask

  task automatic test_reset_mid();
    snap();
    build_frame(8'h01, 56'h11223344556677, 8'h00);
    send_range(0, 5);
    do_reset();
    send_range(0, 11);
    repeat (5) @(negedge clk);
    n_tests++; if (n_fv_rise - b_fv !== 1) begin n_fail++; $display("FAIL rstmid_rise: got %0d exp 1", n_fv_rise - b_fv); end
    n_tests++; if ((n_crc - b_crc) + (n_tmo - b_tmo) + (n_ovr - b_ovr) !== 0) begin n_fail++;
      $display("FAIL rstmid_errs: got %0d pulses exp 0", (n_crc - b_crc) + (n_tmo - b_tmo) + (n_ovr - b_ovr)); end
    // Reset while holding drops frame_valid without a clock edge
    frame_ready = 1'b0;
    send_range(0, 11);
    wait_fv(10, "rsthold_wait");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_async: got %b exp 0", frame_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsthold_busy: got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frame_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = 8'h00; frame_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_resync();
    test_hold_overrun();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
